// File: rtl/occ_axil_rd_responder.sv
// AXI4-Lite read-only responder that serves 256-bit occurrence-table lines from a fixed-latency memory port.
// Writes are accepted and answered with SLVERR. A credit-limited buffer absorbs R-channel backpressure.
module occ_axil_rd_responder #(
    parameter int unsigned AW         = 40,
    parameter int unsigned DW         = 256,
    parameter logic [63:0] BASE_ADDR  = 64'd0,
    parameter int unsigned MEM_AW     = 24,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned RBUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [DW-1:0]     s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    input  logic [AW-1:0]     s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [DW-1:0]     s_wdata,
    input  logic [DW/8-1:0]   s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [DW-1:0]     mem_rdata,
    output logic [15:0]       err_cnt
);

    localparam int unsigned PTR_W = $clog2(RBUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if (DW != 256) begin : g_badDw
        $error("occ_axil_rd_responder: DW must be 256");
    end
    if (RD_LAT < 1) begin : g_badLat
        $error("occ_axil_rd_responder: RD_LAT must be at least 1");
    end
    if ((RBUF_DEPTH < RD_LAT + 1) || ((RBUF_DEPTH & (RBUF_DEPTH - 1)) != 0)) begin : g_badDepth
        $error("occ_axil_rd_responder: RBUF_DEPTH must be a power of 2 and >= RD_LAT+1");
    end

    typedef enum logic [1:0] {W_IDLE, W_GOTAW, W_GOTW, W_RESP} wstate_t;

    logic [63:0]      w_addrExt;
    logic [63:0]      w_off;
    logic [63:0]      w_idxFull;
    logic             w_inRange;
    logic             w_arHs;
    logic             w_rHs;
    logic             w_bHs;
    logic             w_push;
    logic             w_pushErr;
    logic             w_empty;
    logic [1:0]       w_errInc;
    logic [16:0]      w_errSum;
    logic             w_unused;

    logic [CNT_W-1:0] r_cnt;
    logic [RD_LAT-1:0] r_pipeValid;
    logic [RD_LAT-1:0] r_pipeErr;
    logic [DW-1:0]    r_bufData [RBUF_DEPTH];
    logic [1:0]       r_bufResp [RBUF_DEPTH];
    logic [PTR_W:0]   r_wrPtr;
    logic [PTR_W:0]   r_rdPtr;
    wstate_t          r_wState;
    wstate_t          w_wStateNext;

    assign w_unused = ^{s_awaddr, s_wdata, s_wstrb};

    // Line decode: the low five address bits select a byte inside the 32-byte line and are dropped.
    assign w_addrExt = 64'(s_araddr);
    assign w_off     = w_addrExt - BASE_ADDR;
    assign w_idxFull = w_off >> 5;
    assign w_inRange = (w_addrExt >= BASE_ADDR) && ((w_idxFull >> MEM_AW) == 64'd0);

    assign s_arready = !rst && (r_cnt < CNT_W'(RBUF_DEPTH));
    assign w_arHs    = s_arvalid && s_arready;
    assign w_rHs     = s_rvalid && s_rready;
    assign w_bHs     = s_bvalid && s_bready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_arHs && !w_rHs) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (!w_arHs && w_rHs) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en   <= 1'b0;
            mem_addr <= '0;
        end else begin
            mem_en <= w_arHs && w_inRange;
            if (w_arHs && w_inRange) begin
                mem_addr <= w_idxFull[MEM_AW-1:0];
            end
        end
    end

    // Every accepted read walks this pipe so that out-of-range replies keep their place in line.
    // mem_rdata is sampled RD_LAT cycles after the edge that launches mem_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipeValid <= '0;
            r_pipeErr   <= '0;
        end else begin
            r_pipeValid[0] <= w_arHs;
            r_pipeErr[0]   <= !w_inRange;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipeValid[i] <= r_pipeValid[i-1];
                r_pipeErr[i]   <= r_pipeErr[i-1];
            end
        end
    end

    assign w_push    = r_pipeValid[RD_LAT-1];
    assign w_pushErr = r_pipeErr[RD_LAT-1];
    assign w_empty   = (r_wrPtr == r_rdPtr);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RBUF_DEPTH; i++) begin
                r_bufData[i] <= '0;
                r_bufResp[i] <= 2'b00;
            end
        end else if (w_push) begin
            r_bufData[r_wrPtr[PTR_W-1:0]] <= w_pushErr ? '0 : mem_rdata;
            r_bufResp[r_wrPtr[PTR_W-1:0]] <= w_pushErr ? 2'b11 : 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + (PTR_W+1)'(1);
            end
            if (w_rHs) begin
                r_rdPtr <= r_rdPtr + (PTR_W+1)'(1);
            end
        end
    end

    assign s_rvalid = !w_empty;
    assign s_rdata  = r_bufData[r_rdPtr[PTR_W-1:0]];
    assign s_rresp  = r_bufResp[r_rdPtr[PTR_W-1:0]];
    assign s_bresp  = 2'b10;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wState <= W_IDLE;
        end else begin
            r_wState <= w_wStateNext;
        end
    end

    // Write path: collect AW and W in either order, then answer SLVERR and wait for bready.
    always_comb begin
        w_wStateNext = r_wState;
        s_awready    = 1'b0;
        s_wready     = 1'b0;
        s_bvalid     = 1'b0;
        unique case (r_wState)
            W_IDLE: begin
                s_awready = 1'b1;
                s_wready  = 1'b1;
                if (s_awvalid && s_wvalid) begin
                    w_wStateNext = W_RESP;
                end else if (s_awvalid) begin
                    w_wStateNext = W_GOTAW;
                end else if (s_wvalid) begin
                    w_wStateNext = W_GOTW;
                end
            end
            W_GOTAW: begin
                s_wready = 1'b1;
                if (s_wvalid) begin
                    w_wStateNext = W_RESP;
                end
            end
            W_GOTW: begin
                s_awready = 1'b1;
                if (s_awvalid) begin
                    w_wStateNext = W_RESP;
                end
            end
            W_RESP: begin
                s_bvalid = 1'b1;
                if (s_bready) begin
                    w_wStateNext = W_IDLE;
                end
            end
            default: w_wStateNext = W_IDLE;
        endcase
        if (rst) begin
            s_awready = 1'b0;
            s_wready  = 1'b0;
        end
    end

    assign w_errInc = 2'(w_rHs && (s_rresp == 2'b11)) + 2'(w_bHs);
    assign w_errSum = {1'b0, err_cnt} + 17'(w_errInc);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 16'd0;
        end else begin
            err_cnt <= w_errSum[16] ? 16'hFFFF : w_errSum[15:0];
        end
    end

endmodule

// File: tb/tb_occ_axil_rd_responder.sv
// Randomised and directed bench for occ_axil_rd_responder.
// The reference model tracks outstanding reads in a queue and derives every expected response from the address.
module tb_occ_axil_rd_responder;

    logic          clk = 1'b0;
    logic          rst;
    logic [39:0]   s_araddr;
    logic          s_arvalid;
    logic          s_arready;
    logic [255:0]  s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rvalid;
    logic          s_rready;
    logic [39:0]   s_awaddr;
    logic          s_awvalid;
    logic          s_awready;
    logic [255:0]  s_wdata;
    logic [31:0]   s_wstrb;
    logic          s_wvalid;
    logic          s_wready;
    logic [1:0]    s_bresp;
    logic          s_bvalid;
    logic          s_bready;
    logic          mem_en;
    logic [23:0]   mem_addr;
    logic [255:0]  mem_rdata;
    logic [15:0]   err_cnt;

    occ_axil_rd_responder #(
        .AW(40), .DW(256), .BASE_ADDR(64'd0), .MEM_AW(24), .RD_LAT(2), .RBUF_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Memory returns the line index replicated; unrequested cycles return noise.
    logic [255:0] memStage;
    always @(posedge clk) begin
        memStage <= mem_en ? {8{32'(mem_addr)}} : {8{$urandom()}};
    end
    assign mem_rdata = memStage;

    int checks = 0;
    int errors = 0;
    int arWaits = 0;

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    typedef struct packed {
        logic [255:0] data;
        logic [1:0]   resp;
    } rsp_t;

    rsp_t        expQ[$];
    rsp_t        newRsp;
    logic [15:0] mErr;
    logic        gotAw, gotW, bPend;
    logic        expMemEn;
    logic [23:0] expMemAddr;
    logic        rstPrev = 1'b0;
    int          stallCnt;
    logic        expAr, expAw, expW;
    logic [39:0] lineIdx;

    // Reference model: observe at the falling edge, compare, then account for handshakes at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            if (rstPrev) begin
                checkOutput("rst_arready", 256'(s_arready), 256'(0));
                checkOutput("rst_rvalid", 256'(s_rvalid), 256'(0));
                checkOutput("rst_rdata", s_rdata, 256'(0));
                checkOutput("rst_rresp", 256'(s_rresp), 256'(0));
                checkOutput("rst_awready", 256'(s_awready), 256'(0));
                checkOutput("rst_wready", 256'(s_wready), 256'(0));
                checkOutput("rst_bvalid", 256'(s_bvalid), 256'(0));
                checkOutput("rst_bresp", 256'(s_bresp), 256'(2));
                checkOutput("rst_mem_en", 256'(mem_en), 256'(0));
                checkOutput("rst_mem_addr", 256'(mem_addr), 256'(0));
                checkOutput("rst_err_cnt", 256'(err_cnt), 256'(0));
            end
            expQ.delete();
            mErr = 16'd0; gotAw = 1'b0; gotW = 1'b0; bPend = 1'b0;
            expMemEn = 1'b0; expMemAddr = 24'd0; stallCnt = 0;
        end else begin
            expAr = expQ.size() < 4;
            expAw = !bPend && !gotAw;
            expW  = !bPend && !gotW;
            checkOutput("arready", 256'(s_arready), 256'(expAr));
            checkOutput("awready", 256'(s_awready), 256'(expAw));
            checkOutput("wready", 256'(s_wready), 256'(expW));
            checkOutput("bvalid", 256'(s_bvalid), 256'(bPend));
            checkOutput("bresp", 256'(s_bresp), 256'(2));
            checkOutput("err_cnt", 256'(err_cnt), 256'(mErr));
            checkOutput("mem_en", 256'(mem_en), 256'(expMemEn));
            if (expMemEn) checkOutput("mem_addr", 256'(mem_addr), 256'(expMemAddr));
            if (expQ.size() == 0) begin
                checkOutput("spurious_rvalid", 256'(s_rvalid), 256'(0));
            end else if (s_rvalid) begin
                checkOutput("rdata", s_rdata, expQ[0].data);
                checkOutput("rresp", 256'(s_rresp), 256'(expQ[0].resp));
            end
            stallCnt = (expQ.size() != 0 && !s_rvalid) ? stallCnt + 1 : 0;
            checkOutput("r_liveness", 256'(stallCnt <= 8), 256'(1));

            if (s_rvalid && s_rready && expQ.size() != 0) begin
                if (expQ[0].resp == 2'b11 && mErr != 16'hFFFF) mErr++;
                void'(expQ.pop_front());
            end
            if (bPend && s_bready) begin
                bPend = 1'b0;
                if (mErr != 16'hFFFF) mErr++;
            end
            if (s_awvalid && expAw) gotAw = 1'b1;
            if (s_wvalid && expW) gotW = 1'b1;
            if (gotAw && gotW) begin
                bPend = 1'b1; gotAw = 1'b0; gotW = 1'b0;
            end
            expMemEn = 1'b0;
            if (s_arvalid && expAr) begin
                lineIdx = s_araddr / 40'd32;
                if (lineIdx < 40'd16777216) begin
                    newRsp.data = {8{lineIdx[31:0]}};
                    newRsp.resp = 2'b00;
                    expMemEn    = 1'b1;
                    expMemAddr  = lineIdx[23:0];
                end else begin
                    newRsp.data = '0;
                    newRsp.resp = 2'b11;
                end
                expQ.push_back(newRsp);
            end
        end
        rstPrev = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one read and hold it until accepted; leaves arvalid low afterwards.
    task automatic applyStimulus(input logic [39:0] addr);
        int n;
        n = 0;
        s_arvalid = 1'b1;
        s_araddr  = addr;
        while (!s_arready && n < 40) begin
            tick();
            n++;
            arWaits++;
        end
        checkOutput("ar_accept", 256'(s_arready), 256'(1));
        tick();
        s_arvalid = 1'b0;
    endtask

    task automatic measureLatency(input logic [255:0] expData);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!s_rvalid && lat < 20);
        checkOutput("read_latency", 256'(lat), 256'(3));
        checkOutput("read_data", s_rdata, expData);
        checkOutput("read_resp", 256'(s_rresp), 256'(0));
    endtask

    function automatic logic [39:0] randAddr();
        case ($urandom_range(0, 4))
            0:       return 40'($urandom_range(0, 255));
            1:       return 40'h00_1FFF_FFE0 + 40'($urandom_range(0, 31));
            2:       return 40'h00_2000_0000 + 40'($urandom_range(0, 63));
            3:       return {8'($urandom()), 32'($urandom())};
            default: return {11'd0, 29'($urandom())};
        endcase
    endfunction

    initial begin
        int first, last, rvCount;
        rst = 1'b1;
        s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b1;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0;
        s_wvalid = 1'b0; s_bready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        $display("[TB] single read");
        applyStimulus(40'h40);
        measureLatency({8{32'h2}});
        repeat (5) tick();

        $display("[TB] back-to-back reads");
        arWaits = 0; first = -1; last = -1; rvCount = 0;
        fork
            begin
                applyStimulus(40'h00);
                applyStimulus(40'h20);
                applyStimulus(40'h3F);
                applyStimulus(40'h60);
            end
            begin
                for (int i = 0; i < 12; i++) begin
                    @(negedge clk);
                    if (s_rvalid) begin
                        if (first < 0) first = i;
                        last = i;
                        rvCount++;
                    end
                end
            end
        join
        checkOutput("b2b_arready_drop", 256'(arWaits), 256'(0));
        checkOutput("b2b_rvalid_count", 256'(rvCount), 256'(4));
        checkOutput("b2b_rvalid_span", 256'(last - first + 1), 256'(4));
        repeat (3) tick();

        $display("[TB] backpressure");
        s_rready = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(40'h100 + 40'(i * 32));
        s_arvalid = 1'b1;
        s_araddr  = 40'h180;
        repeat (6) tick();
        checkOutput("ar_blocked", 256'(s_arready), 256'(0));
        checkOutput("r_held_valid", 256'(s_rvalid), 256'(1));
        checkOutput("r_head_stable", s_rdata, {8{32'h8}});
        s_rready = 1'b1;
        applyStimulus(40'h180);
        applyStimulus(40'h1A0);
        repeat (8) tick();

        $display("[TB] out-of-range read");
        applyStimulus(40'h00_1FFF_FFE0);
        applyStimulus(40'h00_2000_0000);
        applyStimulus(40'h1E0);
        repeat (8) tick();
        checkOutput("err_after_decerr", 256'(err_cnt), 256'(1));

        $display("[TB] write rejected");
        s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        applyStimulus(40'h20);
        applyStimulus(40'h40);
        tick();
        s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        repeat (2) begin
            checkOutput("b_held", 256'(s_bvalid), 256'(1));
            checkOutput("b_resp", 256'(s_bresp), 256'(2));
            tick();
        end
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        checkOutput("b_done", 256'(s_bvalid), 256'(0));
        repeat (5) tick();
        checkOutput("err_after_slverr", 256'(err_cnt), 256'(2));

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            s_arvalid = 1'($urandom_range(0, 1));
            s_araddr  = randAddr();
            s_rready  = ($urandom_range(0, 3) != 0);
            s_awvalid = ($urandom_range(0, 3) == 0);
            s_wvalid  = ($urandom_range(0, 3) == 0);
            s_bready  = 1'($urandom_range(0, 1));
            s_awaddr  = {8'($urandom()), 32'($urandom())};
            s_wdata   = {8{$urandom()}};
            s_wstrb   = $urandom();
            tick();
        end
        s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_rready = 1'b1; s_bready = 1'b1;
        repeat (10) tick();
        s_bready = 1'b0;

        $display("[TB] reset with reads in flight");
        applyStimulus(40'h60);
        applyStimulus(40'h80);
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (6) begin
            tick();
            checkOutput("no_rvalid_after_rst", 256'(s_rvalid), 256'(0));
        end
        checkOutput("err_cleared", 256'(err_cnt), 256'(0));
        applyStimulus(40'hA0);
        measureLatency({8{32'h5}});
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
